// File: rtl/mc_control_unit_pkg.sv
// Shared types and constants for the multicycle RV32I control unit.
package mc_ctrl_pkg;

  typedef enum logic [4:0] {
    S_FETCH    = 5'd0,
    S_DECODE   = 5'd1,
    S_MEM_ADR  = 5'd2,
    S_MEM_RD   = 5'd3,
    S_MEM_WR   = 5'd4,
    S_MEM_WB   = 5'd5,
    S_EXEC_R   = 5'd6,
    S_EXEC_I   = 5'd7,
    S_JALR_ADR = 5'd8,
    S_JUMP     = 5'd9,
    S_LUI      = 5'd10,
    S_ALU_WB   = 5'd11,
    S_BRANCH   = 5'd12,
    S_TRAP     = 5'd13
  } state_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [1:0] {
    SRCA_PC     = 2'b00,
    SRCA_RS1    = 2'b01,
    SRCA_OLD_PC = 2'b10,
    SRCA_ZERO   = 2'b11
  } src_a_t;

  typedef enum logic [1:0] {
    SRCB_RS2  = 2'b00,
    SRCB_FOUR = 2'b01,
    SRCB_IMM  = 2'b10
  } src_b_t;

  typedef enum logic [1:0] {
    RES_ALU_OUT = 2'b00,
    RES_MEM     = 2'b01,
    RES_ALU     = 2'b10
  } result_src_t;

  localparam logic [3:0] ALU_ADD = 4'b0000;

  typedef enum logic [1:0] {
    ALU_CLS_ADD = 2'b00,
    ALU_CLS_R   = 2'b01,
    ALU_CLS_I   = 2'b10
  } alu_cls_t;

  function automatic state_t decode_next(input logic [6:0] op, input bit trap_en);
    state_t nxt;
    case (op)
      OP_LW, OP_SW: nxt = S_MEM_ADR;
      OP_R:         nxt = S_EXEC_R;
      OP_I:         nxt = S_EXEC_I;
      OP_JAL:       nxt = S_JUMP;
      OP_JALR:      nxt = S_JALR_ADR;
      OP_B:         nxt = S_BRANCH;
      OP_LUI:       nxt = S_LUI;
      OP_AUIPC:     nxt = S_ALU_WB;
      default:      nxt = trap_en ? S_TRAP : S_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Memory request/ready handshake between the control unit and memory.
interface mc_control_unit_if;
  logic mem_req;
  logic mem_write;
  logic instruction_or_data;
  logic mem_ready;

  modport master (output mem_req, output mem_write, output instruction_or_data, input mem_ready);
  modport slave  (input mem_req, input mem_write, input instruction_or_data, output mem_ready);
endinterface

// File: rtl/mc_control_unit_alu_decoder.sv
// Combinational ALU operation decode from state class and funct fields.
module mc_alu_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned ALU_CTRL_W = 4
) (
  input  alu_cls_t              cls,
  input  logic [2:0]            funct3,
  input  logic                  funct7_5,
  output logic [ALU_CTRL_W-1:0] alu_control
);

  logic [3:0] code;

  always_comb begin
    code = ALU_ADD;
    case (cls)
      ALU_CLS_R: code = {funct7_5, funct3};
      // funct7[5] is immediate data for I-type except the shifts, so ADDI never becomes SUB
      ALU_CLS_I: code = (funct3 == 3'b101) ? {funct7_5, funct3} : {1'b0, funct3};
      default:   code = ALU_ADD;
    endcase
    alu_control = ALU_CTRL_W'(code);
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback.
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter bit          TRAP_EN       = 1'b1,
  parameter int unsigned ALU_CTRL_W    = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [6:0]            opcode,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  branch_taken,
  mc_control_unit_if.master     mem,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  reg_write,
  output logic [1:0]            result_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [2:0]            branch_type,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  illegal_insn,
  output logic [4:0]            current_state
);

  state_t   state, state_next;
  logic     rdy;
  logic     req_c, wr_c, iod_c, irw_c, pcw_c, rw_c, ill_c;
  logic [1:0] res_c, a_c, b_c;
  logic [2:0] bt_c;
  alu_cls_t cls_c;
  logic [ALU_CTRL_W-1:0] alu_c;
  logic [5:0] unused_funct7;

  assign unused_funct7 = {funct7[6], funct7[4:0]};
  assign rdy = MEM_HANDSHAKE ? mem.mem_ready : 1'b1;

  mc_alu_decoder #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
    .cls         (cls_c),
    .funct3      (funct3),
    .funct7_5    (funct7[5]),
    .alu_control (alu_c)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_c = 1'b0; wr_c = 1'b0; iod_c = 1'b0;
    irw_c = 1'b0; pcw_c = 1'b0; rw_c = 1'b0; ill_c = 1'b0;
    res_c = RES_ALU_OUT; a_c = SRCA_PC; b_c = SRCB_RS2;
    bt_c  = 3'b000; cls_c = ALU_CLS_ADD;
    case (state)
      S_FETCH: begin
        req_c = 1'b1; b_c = SRCB_FOUR; res_c = RES_ALU;
        irw_c = rdy; pcw_c = rdy;
        if (rdy) state_next = S_DECODE;
      end
      S_DECODE: begin
        a_c = SRCA_OLD_PC; b_c = SRCB_IMM;
        state_next = decode_next(opcode, TRAP_EN);
      end
      S_MEM_ADR: begin
        a_c = SRCA_RS1; b_c = SRCB_IMM;
        state_next = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        req_c = 1'b1; iod_c = 1'b1;
        if (rdy) state_next = S_MEM_WB;
      end
      S_MEM_WR: begin
        req_c = 1'b1; wr_c = 1'b1; iod_c = 1'b1;
        if (rdy) state_next = S_FETCH;
      end
      S_MEM_WB: begin
        res_c = RES_MEM; rw_c = 1'b1;
        state_next = S_FETCH;
      end
      S_EXEC_R: begin
        a_c = SRCA_RS1; b_c = SRCB_RS2; cls_c = ALU_CLS_R;
        state_next = S_ALU_WB;
      end
      S_EXEC_I: begin
        a_c = SRCA_RS1; b_c = SRCB_IMM; cls_c = ALU_CLS_I;
        state_next = S_ALU_WB;
      end
      S_JALR_ADR: begin
        a_c = SRCA_RS1; b_c = SRCB_IMM;
        state_next = S_JUMP;
      end
      S_JUMP: begin
        // PC loads the target held in alu_out while the ALU forms old_pc+4 for rd
        a_c = SRCA_OLD_PC; b_c = SRCB_FOUR; res_c = RES_ALU_OUT; pcw_c = 1'b1;
        state_next = S_ALU_WB;
      end
      S_LUI: begin
        a_c = SRCA_ZERO; b_c = SRCB_IMM;
        state_next = S_ALU_WB;
      end
      S_ALU_WB: begin
        res_c = RES_ALU_OUT; rw_c = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        a_c = SRCA_RS1; b_c = SRCB_RS2; bt_c = funct3;
        res_c = RES_ALU_OUT; pcw_c = branch_taken;
        state_next = S_FETCH;
      end
      S_TRAP: begin
        ill_c = 1'b1;
        state_next = S_TRAP;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Outputs are held at zero throughout reset so no PC/IR write leaks out.
  always_comb begin
    if (reset) begin
      mem.mem_req = 1'b0; mem.mem_write = 1'b0; mem.instruction_or_data = 1'b0;
      ir_write = 1'b0; pc_write = 1'b0; reg_write = 1'b0;
      result_src = 2'b00; alu_src_a = 2'b00; alu_src_b = 2'b00;
      branch_type = 3'b000; alu_control = '0; illegal_insn = 1'b0;
      current_state = S_FETCH;
    end else begin
      mem.mem_req = req_c; mem.mem_write = wr_c; mem.instruction_or_data = iod_c;
      ir_write = irw_c; pc_write = pcw_c; reg_write = rw_c;
      result_src = res_c; alu_src_a = a_c; alu_src_b = b_c;
      branch_type = bt_c;
      alu_control = (cls_c == ALU_CLS_ADD) ? '0 : alu_c;
      illegal_insn = ill_c;
      current_state = state;
    end
  end

endmodule

// File: doc/mc_control_unit.md
# mc_control_unit

Multicycle RV32I control FSM, successor to the current fixed-latency controller. It sequences fetch, decode, execute, memory and writeback for the multicycle datapath, adding LUI, AUIPC and JALR. It also waits on a memory ready handshake for variable-latency memory and optionally traps on illegal opcodes. It drives the datapath mux selects, write enables and ALU control, and sits between the instruction register decode fields and the datapath.

## Interface
- `MEM_HANDSHAKE`, default 1: 1 = memory states wait for `mem_ready`; 0 = `mem_ready` ignored and treated as 1.
- `TRAP_EN`, default 1: 1 = unknown opcode enters TRAP; 0 = unknown opcode retires as a NOP (returns to FETCH).
- `ALU_CTRL_W`, default 4: width of `alu_control`.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `reset  in  1`: synchronous, active-high.
- `opcode  in  7`, `funct3  in  3`, `funct7  in  7`: fields from the instruction register.
- `branch_taken  in  1`: branch comparator result from the datapath.
- `mem_ready  in  1`: memory completes the current access this cycle.
- `mem_req  out  1`: memory access requested.
- `mem_write  out  1`: store enable.
- `instruction_or_data  out  1`: 0 = PC address, 1 = alu_out address.
- `ir_write`, `pc_write`, `reg_write  out  1`: register write enables.
- `result_src  out  2`: 00 = alu_out, 01 = mem data, 10 = ALU result.
- `alu_src_a  out  2`: 00 = PC, 01 = rs1, 10 = old_pc, 11 = zero.
- `alu_src_b  out  2`: 00 = rs2, 01 = constant 4, 10 = immediate.
- `branch_type  out  3`: funct3 in BRANCH, else 0.
- `alu_control  out  ALU_CTRL_W`: ALU operation; 0 = add.
- `illegal_insn  out  1`: sticky trap indicator.
- `current_state  out  5`: state register, for debug.

## Operation
- **Defaults every cycle:** all enables, `mem_req`, `branch_type`, `alu_control` and `illegal_insn` are 0; all mux selects are 00.
- **FETCH:**
  - Outputs: `mem_req`=1, `alu_src_a`=00, `alu_src_b`=01, add, `result_src`=10.
  - `ir_write` and `pc_write` = `mem_ready`.
  - Stays in FETCH until `mem_ready`, then goes to DECODE.
- **DECODE:** `alu_src_a`=10, `alu_src_b`=10, add (computes the branch/JAL/AUIPC target into alu_out). Next state by opcode:
  - LW or SW -> MEM_ADR
  - R -> EXEC_R
  - I-ALU -> EXEC_I
  - JAL -> JUMP
  - JALR -> JALR_ADR
  - B -> BRANCH
  - LUI -> LUI
  - AUIPC -> ALU_WB
  - anything else -> TRAP if `TRAP_EN`, else FETCH
- **MEM_ADR:** `alu_src_a`=01, `alu_src_b`=10, add. Next is MEM_RD for a load, MEM_WR for a store.
- **MEM_RD:** `mem_req`=1, `instruction_or_data`=1. Holds until `mem_ready`, then MEM_WB.
- **MEM_WR:** `mem_req`=1, `mem_write`=1, `instruction_or_data`=1. Holds until `mem_ready`, then FETCH.
- **MEM_WB:** `result_src`=01, `reg_write`=1. Next is FETCH.
- **EXEC_R:** `alu_src_a`=01, `alu_src_b`=00, `alu_control`={funct7[5],funct3}. Next is ALU_WB.
- **EXEC_I:** `alu_src_a`=01, `alu_src_b`=10. Next is ALU_WB.
  - `alu_control`={funct7[5],funct3} only when funct3=101 (SRLI/SRAI).
  - Otherwise `alu_control`={0,funct3}, so ADDI is never decoded as SUB.
- **JALR_ADR:** `alu_src_a`=01, `alu_src_b`=10, add. Next is JUMP. Clearing bit 0 of the target is the datapath's job.
- **JUMP:** `alu_src_a`=10, `alu_src_b`=01, add, `result_src`=00, `pc_write`=1. Next is ALU_WB, which writes old_pc+4 to rd.
- **LUI:** `alu_src_a`=11, `alu_src_b`=10, add. Next is ALU_WB.
- **ALU_WB:** `result_src`=00, `reg_write`=1. Next is FETCH.
- **BRANCH:** `alu_src_a`=01, `alu_src_b`=00, `branch_type`=funct3, `result_src`=00, `pc_write`=`branch_taken`. Next is FETCH.
- **TRAP:** `illegal_insn`=1, all enables 0. Stays in TRAP until reset.
- **Unreachable encodings** go to FETCH with default outputs.

## Timing
- **Reset:**
  - On the clock edge with `reset`=1, the state register becomes FETCH.
  - While `reset`=1, all outputs are forced to 0 and `current_state` reads FETCH, so there is no spurious PC or IR write during reset.
  - Reset wins over every other event, including mid-wait and in TRAP.
- **Zero-wait instruction latencies** (`mem_ready` held at 1 or `MEM_HANDSHAKE`=0):

  | Instruction | Cycles |
  |---|---|
  | LW | 5 |
  | SW | 4 |
  | R, I, LUI | 4 |
  | AUIPC | 3 |
  | JAL | 4 |
  | JALR | 5 |
  | B | 3 |

- **Each wait cycle** in FETCH, MEM_RD or MEM_WR adds 1 cycle.
- **Signal stability during waits:** `mem_req`, `mem_write`, `instruction_or_data` and the mux selects stay stable throughout a wait.
- **Ready gating:** a write enable is asserted only in the cycle where `mem_ready`=1. The one exception is `mem_write`, which is held for the whole MEM_WR wait.
- **Fields must be stable:** `opcode`/`funct*` are read in DECODE and later states and must not change until the next FETCH completes, which holds because `ir_write` is asserted only in FETCH.

## Structure
- **Package `mc_ctrl_pkg`** holds:
  - the state enum (5-bit)
  - opcode constants (LW, SW, R, I, B, JAL, JALR, LUI, AUIPC)
  - the `alu_src_a`/`alu_src_b`/`result_src` select encodings
  - the ALU add code
- **Sub-module `mc_alu_decoder`:** purely combinational; maps (state class, funct3, funct7[5]) to `alu_control`.
- **Top level:** the state register, the next-state logic and the output decode.

## Test plan
- **ADD x3,x1,x2** with `mem_ready`=1: states FETCH->DECODE->EXEC_R->ALU_WB->FETCH; `alu_control`=0000; `reg_write`=1 only in cycle 4.
- **ADDI with funct7 bits set** (imm[10]=1, opcode 0010011, funct3 000): `alu_control`=0000. With funct3=101 and funct7[5]=1 (SRAI): `alu_control`=1101.
- **LW with `mem_ready` low** for 3 cycles in MEM_RD:
  - remains in MEM_RD for 4 cycles with `mem_req`=1 and `instruction_or_data`=1;
  - MEM_WB then follows;
  - total of 8 cycles.
- **BEQ (funct3 000):** `branch_taken`=1 gives `pc_write`=1 in BRANCH. `branch_taken`=0 gives `pc_write`=0. Both return to FETCH, and `branch_type`=000.
- **JALR:** visits JALR_ADR (`alu_src_a`=01), then JUMP (`pc_write`=1), then ALU_WB (`reg_write`=1).
- **Opcode 1111111 and reset:**
  - With `TRAP_EN`=1: TRAP with `illegal_insn`=1 held for 10 cycles; after reset, FETCH with `illegal_insn`=0.
  - With `TRAP_EN`=0: returns to FETCH with no writes.
  - Reset asserted mid MEM_WR: the next state is FETCH and `mem_write`=0 in the reset cycle.
